mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result as an effective address (loads/stores) or as a pass-through value (all other instructions).
- Drives a single-outstanding req/ack data-memory port with byte strobes; formats load data with sign or zero extension.
- Presents a registered writeback result and stalls upstream while a memory access is in flight.

---
 rtl/mem_access_if.sv | 32 +++
 rtl/mem_access.sv | 108 ++++++++++
 tb/tb_mem_access.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: upstream, data-memory and writeback signals of the memory-access stage
interface mem_access_if;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_res;
  logic [31:0] reg_2;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_err;
  modport master (
    output valid, opcode, funct3, rd, alu_res, reg_2, dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, wb_rd, wb_data, misalign_err, bus_err
  );
  modport slave (
    input  valid, opcode, funct3, rd, alu_res, reg_2, dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, wb_rd, wb_data, misalign_err, bus_err
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: load/store stage with single-outstanding req/ack port, load extension and registered writeback
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  mem_access_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic [31:0] res_q;
  logic consumed;
  logic is_mem, is_store, misal, same, take, issue;
  logic [3:0] strb;
  logic [31:0] wdata, ld;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_store = bus.opcode == 7'b0100011;
    is_mem = is_store || bus.opcode == 7'b0000011;
    misal = (bus.funct3[1:0] == 2'b00 && !bus.funct3[2]) || bus.funct3 == 3'b100 ? 1'b0 :
            bus.funct3 == 3'b001 || bus.funct3 == 3'b101 ? bus.alu_res[0] :
            bus.funct3 == 3'b010 ? |bus.alu_res[1:0] : 1'b1;
    // a held instruction that already finished (ack or timeout) must not be re-issued
    same = consumed && {bus.opcode, bus.funct3, bus.rd, bus.alu_res} == {op_q, f3_q, rd_q, res_q};
    take = bus.valid && !same;
    issue = take && is_mem && !misal;
    bus.stall = state == IDLE ? issue : !bus.dmem_ack;
    strb = !is_store ? 4'b0000 :
           bus.funct3[1:0] == 2'b00 ? 4'b0001 << bus.alu_res[1:0] :
           bus.funct3[1:0] == 2'b01 ? 4'b0011 << bus.alu_res[1:0] : 4'b1111;
    wdata = bus.funct3[1:0] == 2'b00 ? {4{bus.reg_2[7:0]}} :
            bus.funct3[1:0] == 2'b01 ? {2{bus.reg_2[15:0]}} : bus.reg_2;
    b = bus.dmem_rdata[{res_q[1:0], 3'b000} +: 8];
    h = res_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    ld = f3_q == 3'b000 ? {{24{b[7]}}, b} :
         f3_q == 3'b100 ? {24'd0, b} :
         f3_q == 3'b001 ? {{16{h[15]}}, h} :
         f3_q == 3'b101 ? {16'd0, h} : bus.dmem_rdata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      f3_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      consumed <= 1'b0;
      bus.dmem_req <= 1'b0;
      bus.dmem_we <= 1'b0;
      bus.dmem_addr <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_wstrb <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd <= '0;
      bus.wb_data <= '0;
      bus.misalign_err <= 1'b0;
      bus.bus_err <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.bus_err <= 1'b0;
      if (state == IDLE) begin
        consumed <= 1'b0;
        if (take && !is_mem) begin
          bus.wb_valid <= 1'b1;
          bus.wb_rd <= bus.rd;
          bus.wb_data <= bus.alu_res;
        end else if (take && misal) begin
          bus.misalign_err <= 1'b1;
        end else if (issue) begin
          bus.dmem_req <= 1'b1;
          bus.dmem_we <= is_store;
          bus.dmem_addr <= {bus.alu_res[31:2], 2'b00};
          bus.dmem_wstrb <= strb;
          bus.dmem_wdata <= wdata;
          op_q <= bus.opcode;
          f3_q <= bus.funct3;
          rd_q <= bus.rd;
          res_q <= bus.alu_res;
          cnt <= '0;
          state <= WAIT;
        end
      end else if (bus.dmem_ack) begin
        bus.dmem_req <= 1'b0;
        bus.wb_valid <= 1'b1;
        bus.wb_rd <= bus.dmem_we ? 5'd0 : rd_q;
        bus.wb_data <= bus.dmem_we ? 32'd0 : ld;
        consumed <= 1'b1;
        state <= IDLE;
      end else if (cnt == LAST) begin
        bus.dmem_req <= 1'b0;
        bus.bus_err <= 1'b1;
        consumed <= 1'b1;
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of pass-through, stores, load extension, misalignment, timeout and reset
module tb_mem_access;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int n;
  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;
  mem_access_if bus ();
  mem_access #(.TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
    bus.valid = 1'b1;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.rd = r;
    bus.alu_res = a;
    bus.reg_2 = d;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata, input logic [4:0] r, input logic [31:0] exp);
    drive(LOAD, f3, r, a, 32'h0);
    #1 chk({tag, "_stall_issue"}, 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk({tag, "_req"}, 32'(bus.dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(bus.dmem_we), 32'd0);
    chk({tag, "_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_strb"}, 32'(bus.dmem_wstrb), 32'd0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = rdata;
    #1 chk({tag, "_stall_ack"}, 32'(bus.stall), 32'd0);
    @(negedge clk);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(r));
    chk({tag, "_wb_data"}, bus.wb_data, exp);
    chk({tag, "_req_drop"}, 32'(bus.dmem_req), 32'd0);
    bus.dmem_ack = 1'b0;
    bus.valid = 1'b0;
  endtask
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input int cyc, input logic [3:0] strb, input logic [31:0] wd);
    drive(STORE, f3, 5'd7, a, d);
    #1 chk({tag, "_stall_issue"}, 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk({tag, "_req"}, 32'(bus.dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(bus.dmem_we), 32'd1);
    chk({tag, "_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_strb"}, 32'(bus.dmem_wstrb), 32'(strb));
    chk({tag, "_wdata"}, bus.dmem_wdata, wd);
    for (int i = 1; i < cyc; i++) begin
      #1 chk({tag, "_stall_wait"}, 32'(bus.stall), 32'd1);
      @(negedge clk);
      chk({tag, "_req_held"}, 32'(bus.dmem_req), 32'd1);
      chk({tag, "_wdata_held"}, bus.dmem_wdata, wd);
    end
    bus.dmem_ack = 1'b1;
    #1 chk({tag, "_stall_ack"}, 32'(bus.stall), 32'd0);
    @(negedge clk);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
    chk({tag, "_wb_data"}, bus.wb_data, 32'd0);
    chk({tag, "_req_drop"}, 32'(bus.dmem_req), 32'd0);
    bus.dmem_ack = 1'b0;
    bus.valid = 1'b0;
  endtask
  initial begin
    bus.valid = 1'b0;
    bus.opcode = '0;
    bus.funct3 = '0;
    bus.rd = '0;
    bus.alu_res = '0;
    bus.reg_2 = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_errs", 32'({bus.misalign_err, bus.bus_err}), 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    drive(ALU, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
    #1 chk("add_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    chk("add_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("add_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("add_wb_data", bus.wb_data, 32'h0000_1234);
    chk("add_stall2", 32'(bus.stall), 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    chk("add_pulse_end", 32'(bus.wb_valid), 32'd0);
    do_store("sb", 3'b000, 32'h102, 32'hAABBCCDD, 3, 4'b0100, 32'hDDDDDDDD);
    do_store("sh", 3'b001, 32'h106, 32'h1234ABCD, 1, 4'b1100, 32'hABCDABCD);
    do_store("sw", 3'b010, 32'h10C, 32'hCAFEF00D, 2, 4'b1111, 32'hCAFEF00D);
    do_load("lb", 3'b000, 32'h203, 32'h80FF_0000, 5'd9, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80FF_0000, 5'd10, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h202, 32'h80FF_0000, 5'd11, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 32'h202, 32'h80FF_0000, 5'd12, 32'h0000_80FF);
    do_load("lb0", 3'b000, 32'h200, 32'h1234_5680, 5'd13, 32'hFFFFFF80);
    do_load("lw", 3'b010, 32'h200, 32'h80FF_0000, 5'd14, 32'h80FF_0000);
    drive(LOAD, 3'b010, 5'd3, 32'h102, 32'h0);
    #1 chk("mis_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    chk("mis_err", 32'(bus.misalign_err), 32'd1);
    chk("mis_req", 32'(bus.dmem_req), 32'd0);
    chk("mis_wb", 32'(bus.wb_valid), 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    chk("mis_pulse_end", 32'(bus.misalign_err), 32'd0);
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_wb", 32'(bus.wb_valid), 32'd0);
    chk("idle_ack_req", 32'(bus.dmem_req), 32'd0);
    bus.dmem_ack = 1'b0;
    drive(LOAD, 3'b010, 5'd4, 32'h300, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.dmem_req) break;
      n++;
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_bus_err", 32'(bus.bus_err), 32'd1);
    chk("to_req", 32'(bus.dmem_req), 32'd0);
    chk("to_wb", 32'(bus.wb_valid), 32'd0);
    #1 chk("to_stall", 32'(bus.stall), 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    chk("to_pulse_end", 32'(bus.bus_err), 32'd0);
    drive(LOAD, 3'b010, 5'd6, 32'h400, 32'h0);
    @(negedge clk);
    chk("rw_req", 32'(bus.dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1 chk("rw_async_drop", 32'(bus.dmem_req), 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    chk("rw_no_wb", 32'(bus.wb_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    do_load("post_rst_lw", 3'b010, 32'h0, 32'h1234_5678, 5'd8, 32'h1234_5678);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
